// File: rtl/vend_if.sv
`default_nettype none
// ============================================================================
//  Module   : vend_if
//  Purpose  : Signal bundle between the vending controller and its
//             surroundings (coin encoder, item dispenser, change chute,
//             seven-segment display drivers).
//  Ports    : master - environment side: drives coin events, cancel and
//                      actuator handshakes; observes requests and status.
//             slave  - controller side: mirror image of master.
//  Revision : 1.0 - initial release
// ============================================================================
interface vend_if #(
   parameter int CREDIT_W = 5
) ();
   logic                coin_valid;
   logic [1:0]          coin_type;
   logic                cancel;
   logic                vend_ack;
   logic                chg_ready;
   logic                vend_req;
   logic                chg_valid;
   logic [1:0]          chg_type;
   logic                coin_reject;
   logic [CREDIT_W-1:0] credit;
   logic [2:0]          state;

   modport master (
      output coin_valid, coin_type, cancel, vend_ack, chg_ready,
      input  vend_req, chg_valid, chg_type, coin_reject, credit, state
   );

   modport slave (
      input  coin_valid, coin_type, cancel, vend_ack, chg_ready,
      output vend_req, chg_valid, chg_type, coin_reject, credit, state
   );
endinterface
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
//  Module   : vend_controller
//  Purpose  : Coin-operated vending sequencer. Accumulates credit in
//             half-farthing units, requests a dispense once the price is
//             met, then pays change / refunds one coin per handshake,
//             largest coin first.
//  Ports    : CLK  - clock, rising edge
//             RES  - asynchronous active-high reset
//             bus  - vend_if.slave: coin_valid/coin_type/cancel in,
//                    vend_req/vend_ack dispense handshake,
//                    chg_valid/chg_type/chg_ready change handshake,
//                    coin_reject pulse, credit and state for display
//  Revision : 1.0 - initial release
// ============================================================================
module vend_controller #(
   parameter int PRICE    = 6,
   parameter int CREDIT_W = 5,
   parameter int TIMEOUT  = 255
) (
   input wire logic CLK,
   input wire logic RES,
   vend_if.slave    bus
);

   localparam int c_cnt_w = $clog2(TIMEOUT);

   localparam logic [CREDIT_W-1:0] c_price   = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] c_val_hf  = CREDIT_W'(1);
   localparam logic [CREDIT_W-1:0] c_val_f   = CREDIT_W'(2);
   localparam logic [CREDIT_W-1:0] c_val_p   = CREDIT_W'(8);
   localparam logic [c_cnt_w-1:0]  c_to_last = c_cnt_w'(TIMEOUT - 1);
   localparam logic [c_cnt_w-1:0]  c_cnt_one = c_cnt_w'(1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_VEND    = 3'd2,
      ST_CHANGE  = 3'd3,
      ST_REFUND  = 3'd4
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
   logic [c_cnt_w-1:0]  r_count, w_count_nxt;
   logic                r_reject, w_reject_nxt;

   logic [CREDIT_W-1:0] w_coin_val;
   logic [CREDIT_W-1:0] w_credit_sum;
   logic                w_coin_ok;
   logic                w_accepting;
   logic                w_payout;
   logic [CREDIT_W-1:0] w_chg_val;
   logic [1:0]          w_chg_code;

   // Incoming coin value; code 3 contributes nothing and is rejected.
   always_comb begin
      w_coin_val = '0;
      case (bus.coin_type)
         2'd0:    w_coin_val = c_val_hf;
         2'd1:    w_coin_val = c_val_f;
         2'd2:    w_coin_val = c_val_p;
         default: w_coin_val = '0;
      endcase
   end

   // Largest coin that does not exceed the remaining credit.
   always_comb begin
      if (r_credit >= c_val_p) begin
         w_chg_val  = c_val_p;
         w_chg_code = 2'd2;
      end else if (r_credit >= c_val_f) begin
         w_chg_val  = c_val_f;
         w_chg_code = 2'd1;
      end else begin
         w_chg_val  = c_val_hf;
         w_chg_code = 2'd0;
      end
   end

   assign w_accepting  = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
   assign w_payout     = (r_state == ST_CHANGE) || (r_state == ST_REFUND);
   assign w_coin_ok    = bus.coin_valid && (bus.coin_type != 2'd3) && w_accepting;
   // Cannot overflow: while accepting, credit < PRICE, and PRICE-1+8 fits.
   assign w_credit_sum = r_credit + w_coin_val;

   always_comb begin
      w_state_nxt  = r_state;
      w_credit_nxt = r_credit;
      w_count_nxt  = '0;
      // Any coin we do not bank goes back out the return chute.
      w_reject_nxt = bus.coin_valid && !w_coin_ok;

      case (r_state)
         ST_IDLE: begin
            if (w_coin_ok) begin
               w_credit_nxt = w_credit_sum;
               w_state_nxt  = (w_credit_sum >= c_price) ? ST_VEND : ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (w_coin_ok) begin
               w_credit_nxt = w_credit_sum;
            end
            // A coin arriving with cancel is banked first, then refunded.
            if (w_coin_ok && (w_credit_sum >= c_price)) begin
               w_state_nxt = ST_VEND;
            end else if (bus.cancel) begin
               w_state_nxt = ST_REFUND;
            end else if (w_coin_ok) begin
               w_count_nxt = '0;
            end else if (r_count == c_to_last) begin
               w_state_nxt = ST_REFUND;
            end else begin
               w_count_nxt = r_count + c_cnt_one;
            end
         end
         ST_VEND: begin
            if (bus.vend_ack) begin
               w_credit_nxt = r_credit - c_price;
               w_state_nxt  = (r_credit == c_price) ? ST_IDLE : ST_CHANGE;
            end
         end
         ST_CHANGE, ST_REFUND: begin
            if (bus.chg_ready) begin
               w_credit_nxt = r_credit - w_chg_val;
               if (r_credit == w_chg_val) begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt  = ST_IDLE;
            w_credit_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         r_state  <= ST_IDLE;
         r_credit <= '0;
         r_count  <= '0;
         r_reject <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_credit <= w_credit_nxt;
         r_count  <= w_count_nxt;
         r_reject <= w_reject_nxt;
      end
   end

   // All outputs decode registered state only.
   assign bus.vend_req    = (r_state == ST_VEND);
   assign bus.chg_valid   = w_payout;
   assign bus.chg_type    = w_payout ? w_chg_code : 2'd0;
   assign bus.coin_reject = r_reject;
   assign bus.credit      = r_credit;
   assign bus.state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vend_controller
//  Purpose  : Directed self-checking bench for vend_controller
//             (PRICE=6, CREDIT_W=5, TIMEOUT=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vend_controller;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   n_rej;

   vend_if #(.CREDIT_W(5)) bus ();

   vend_controller #(
      .PRICE    (6),
      .CREDIT_W (5),
      .TIMEOUT  (4)
   ) dut (
      .CLK (clk),
      .RES (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock; leave the bench 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_coin(input logic v, input logic [1:0] t);
      bus.coin_valid = v;
      bus.coin_type  = t;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst            = 1'b1;
      bus.coin_valid = 1'b0;
      bus.coin_type  = 2'd0;
      bus.cancel     = 1'b0;
      bus.vend_ack   = 1'b0;
      bus.chg_ready  = 1'b0;
      step();
      step();
      check("rst_state", bus.state, 0);
      check("rst_credit", bus.credit, 0);
      check("rst_vend_req", bus.vend_req, 0);
      check("rst_chg_valid", bus.chg_valid, 0);
      check("rst_chg_type", bus.chg_type, 0);
      check("rst_reject", bus.coin_reject, 0);
      rst = 1'b0;

      // Penny, ack and ready tied high: vend then one farthing change.
      bus.vend_ack  = 1'b1;
      bus.chg_ready = 1'b1;
      set_coin(1'b1, 2'd2);
      step();
      set_coin(1'b0, 2'd0);
      check("t1_credit8", bus.credit, 8);
      check("t1_state_vend", bus.state, 2);
      check("t1_vend_req", bus.vend_req, 1);
      step();
      check("t1_credit2", bus.credit, 2);
      check("t1_state_change", bus.state, 3);
      check("t1_chg_valid", bus.chg_valid, 1);
      check("t1_chg_type", bus.chg_type, 1);
      check("t1_vend_req_low", bus.vend_req, 0);
      step();
      check("t1_state_idle", bus.state, 0);
      check("t1_credit0", bus.credit, 0);
      check("t1_chg_valid_low", bus.chg_valid, 0);

      // Invalid coin code while idle.
      set_coin(1'b1, 2'd3);
      step();
      set_coin(1'b0, 2'd0);
      check("inv_reject", bus.coin_reject, 1);
      check("inv_credit", bus.credit, 0);
      check("inv_state", bus.state, 0);
      step();
      check("inv_reject_drop", bus.coin_reject, 0);

      // Six half-farthings: exact price, no change.
      for (int i = 1; i <= 6; i++) begin
         set_coin(1'b1, 2'd0);
         step();
         check("t2_credit", bus.credit, i);
         check("t2_state", bus.state, (i < 6) ? 1 : 2);
      end
      set_coin(1'b0, 2'd0);
      step();
      check("t2_idle", bus.state, 0);
      check("t2_credit0", bus.credit, 0);
      check("t2_no_chg", bus.chg_valid, 0);

      // Farthing, cancel three cycles later.
      set_coin(1'b1, 2'd1);
      step();
      set_coin(1'b0, 2'd0);
      check("t3_collect", bus.state, 1);
      check("t3_credit2", bus.credit, 2);
      step();
      step();
      bus.cancel = 1'b1;
      step();
      bus.cancel = 1'b0;
      check("t3_refund", bus.state, 4);
      check("t3_chg_valid", bus.chg_valid, 1);
      check("t3_chg_type", bus.chg_type, 1);
      check("t3_no_vend", bus.vend_req, 0);
      step();
      check("t3_idle", bus.state, 0);
      check("t3_credit0", bus.credit, 0);

      // Coin and cancel together: coin banked, then refunded.
      set_coin(1'b1, 2'd1);
      step();
      set_coin(1'b1, 2'd1);
      bus.cancel = 1'b1;
      step();
      set_coin(1'b0, 2'd0);
      bus.cancel = 1'b0;
      check("cc_refund", bus.state, 4);
      check("cc_credit4", bus.credit, 4);
      step();
      check("cc_credit2", bus.credit, 2);
      step();
      check("cc_idle", bus.state, 0);

      // Timeout after exactly 4 idle cycles, then a stalled refund.
      bus.chg_ready = 1'b0;
      set_coin(1'b1, 2'd1);
      step();
      set_coin(1'b0, 2'd0);
      for (int i = 1; i <= 4; i++) begin
         step();
         check("t4_timeout_state", bus.state, (i < 4) ? 1 : 4);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         check("t4_stall_valid", bus.chg_valid, 1);
         check("t4_stall_type", bus.chg_type, 1);
         check("t4_stall_credit", bus.credit, 2);
      end
      bus.chg_ready = 1'b1;
      step();
      check("t4_idle", bus.state, 0);
      check("t4_credit0", bus.credit, 0);

      // Penny with ack held off; farthing injected during VEND.
      bus.vend_ack  = 1'b0;
      bus.chg_ready = 1'b0;
      set_coin(1'b1, 2'd2);
      step();
      n_rej = 0;
      for (int i = 0; i < 10; i++) begin
         set_coin(i == 3, 2'd1);
         step();
         if (bus.coin_reject) n_rej++;
         check("t5_credit8", bus.credit, 8);
         check("t5_vend_req", bus.vend_req, 1);
      end
      set_coin(1'b0, 2'd0);
      check("t5_reject_pulses", n_rej, 1);
      bus.vend_ack = 1'b1;
      step();
      check("t5_change", bus.state, 3);
      check("t5_credit2", bus.credit, 2);
      check("t5_vend_req_low", bus.vend_req, 0);

      // Asynchronous reset mid-CHANGE.
      step();
      check("t6_hold_change", bus.state, 3);
      rst = 1'b1;
      #1;
      check("t6_state", bus.state, 0);
      check("t6_credit", bus.credit, 0);
      check("t6_chg_valid", bus.chg_valid, 0);
      check("t6_chg_type", bus.chg_type, 0);
      check("t6_vend_req", bus.vend_req, 0);
      #1;
      rst = 1'b0;
      bus.chg_ready = 1'b1;
      set_coin(1'b1, 2'd2);
      step();
      set_coin(1'b0, 2'd0);
      check("t6_fresh_credit", bus.credit, 8);
      check("t6_fresh_vend", bus.state, 2);
      step();
      check("t6_fresh_change", bus.credit, 2);
      step();
      check("t6_fresh_idle", bus.state, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
